// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and default score constants
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int DEFAULT_SCORE_W   = 4;
    localparam int DEFAULT_WIN_SCORE = 11;

endpackage

// File: rtl/pause_timer.sv
// rtl/pause_timer.sv - post-point pause countdown
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   load  : reload the count with HOLD_CYCLES
//   count : decrement while nonzero
//   done  : last pause cycle (count == 1)
module pause_timer #(
    parameter int HOLD_CYCLES = 4,
    parameter int W           = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= W'(HOLD_CYCLES);
        end else if (count && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Loaded with HOLD_CYCLES on the point edge, so hitting 1 marks the
    // final pause cycle and the FSM leaves HOLD on the following edge.
    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/match_scorer.sv
// rtl/match_scorer.sv - multi-player match score keeper with post-point pause
//   clk, rst  : clock and synchronous active-high reset
//   start     : begins a match from IDLE or OVER
//   point     : one bit per player, lowest set index wins the cycle
//   scores    : packed scores, player i at [i*SCORE_W +: SCORE_W]
//   point_ack : one-cycle pulse when a point is registered
//   serve_to  : last player to score
//   in_play   : high in PLAY
//   game_over : high in OVER
//   winner    : match winner, valid while game_over
module match_scorer
    import pong_pkg::*;
#(
    parameter int N_PLAYERS   = 2,
    parameter int SCORE_W     = DEFAULT_SCORE_W,
    parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_PLAYERS-1:0]           point,
    output logic [N_PLAYERS*SCORE_W-1:0]   scores,
    output logic                           point_ack,
    output logic [$clog2(N_PLAYERS)-1:0]   serve_to,
    output logic                           in_play,
    output logic                           game_over,
    output logic [$clog2(N_PLAYERS)-1:0]   winner
);

    localparam int IDX_W   = $clog2(N_PLAYERS);
    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t                         state_q, state_d;
    logic [N_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
    logic                           ack_q, ack_d;
    logic [IDX_W-1:0]               serve_q, serve_d;
    logic [IDX_W-1:0]               winner_q, winner_d;
    logic                           timer_load, timer_count, timer_done;

    // Scanning downward leaves the lowest set index as the final assignment.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_PLAYERS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    pause_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .W           (TIMER_W)
    ) u_pause_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .count (timer_count),
        .done  (timer_done)
    );

    always_comb begin
        logic [IDX_W-1:0]   idx;
        logic [SCORE_W-1:0] cur;
        logic [SCORE_W-1:0] inc;
        int                 base;

        state_d     = state_q;
        scores_d    = scores_q;
        ack_d       = 1'b0;
        serve_d     = serve_q;
        winner_d    = winner_q;
        timer_load  = 1'b0;
        timer_count = 1'b0;
        idx         = lowest_set(point);
        base        = int'(idx) * SCORE_W;
        cur         = scores_q[base +: SCORE_W];
        inc         = cur + SCORE_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = PLAY;
                    scores_d = '0;
                end
            end
            PLAY: begin
                // A score already at WIN_VAL cannot be seen here, since
                // reaching it moves to OVER; the guard keeps it from wrapping.
                if ((|point) && (cur != WIN_VAL)) begin
                    scores_d[base +: SCORE_W] = inc;
                    ack_d   = 1'b1;
                    serve_d = idx;
                    if (inc == WIN_VAL) begin
                        state_d  = OVER;
                        winner_d = idx;
                    end else begin
                        state_d    = HOLD;
                        timer_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                timer_count = 1'b1;
                if (timer_done) begin
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (start) begin
                    state_d  = PLAY;
                    scores_d = '0;
                    winner_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            scores_q <= '0;
            ack_q    <= 1'b0;
            serve_q  <= '0;
            winner_q <= '0;
        end else begin
            state_q  <= state_d;
            scores_q <= scores_d;
            ack_q    <= ack_d;
            serve_q  <= serve_d;
            winner_q <= winner_d;
        end
    end

    assign scores    = scores_q;
    assign point_ack = ack_q;
    assign serve_to  = serve_q;
    assign winner    = winner_q;
    assign in_play   = (state_q == PLAY);
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_match_scorer.sv
// tb/tb_match_scorer.sv - directed bench for match_scorer, 2-player and 4-player builds
module tb_match_scorer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [1:0]  point_a = '0;
    logic [7:0]  scores_a;
    logic        ack_a;
    logic [0:0]  serve_a;
    logic        in_play_a;
    logic        over_a;
    logic [0:0]  winner_a;

    logic        start_b = 1'b0;
    logic [3:0]  point_b = '0;
    logic [11:0] scores_b;
    logic        ack_b;
    logic [1:0]  serve_b;
    logic        in_play_b;
    logic        over_b;
    logic [1:0]  winner_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    match_scorer u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .point     (point_a),
        .scores    (scores_a),
        .point_ack (ack_a),
        .serve_to  (serve_a),
        .in_play   (in_play_a),
        .game_over (over_a),
        .winner    (winner_a)
    );

    match_scorer #(
        .N_PLAYERS (4),
        .SCORE_W   (3),
        .WIN_SCORE (7)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .point     (point_b),
        .scores    (scores_b),
        .point_ack (ack_b),
        .serve_to  (serve_b),
        .in_play   (in_play_b),
        .game_over (over_b),
        .winner    (winner_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after the point edge: three more HOLD cycles, then PLAY.
    task automatic wait_hold(input bit use_b, input logic [31:0] exp_scores);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_in_play", use_b ? 32'(in_play_b) : 32'(in_play_a), 32'd0);
            chk("hold_ack",     use_b ? 32'(ack_b)     : 32'(ack_a),     32'd0);
            chk("hold_scores",  use_b ? 32'(scores_b)  : 32'(scores_a),  exp_scores);
        end
        tick();
        chk("hold_end_in_play", use_b ? 32'(in_play_b) : 32'(in_play_a), 32'd1);
        chk("hold_end_scores",  use_b ? 32'(scores_b)  : 32'(scores_a),  exp_scores);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_scores",  32'(scores_a),  32'h00);
        chk("rst_ack",     32'(ack_a),     32'd0);
        chk("rst_in_play", 32'(in_play_a), 32'd0);
        chk("rst_over",    32'(over_a),    32'd0);
        chk("rst_serve",   32'(serve_a),   32'd0);
        chk("rst_winner",  32'(winner_a),  32'd0);
        chk("rst_scores_b", 32'(scores_b), 32'h000);

        // First cycle after reset is IDLE: point ignored
        point_a = 2'b01;
        tick();
        chk("idle_pt_scores", 32'(scores_a),  32'h00);
        chk("idle_pt_ack",    32'(ack_a),     32'd0);
        chk("idle_in_play",   32'(in_play_a), 32'd0);

        // start with point in IDLE: start wins, point dropped
        start_a = 1'b1;
        point_a = 2'b01;
        tick();
        start_a = 1'b0;
        chk("start_in_play", 32'(in_play_a), 32'd1);
        chk("start_scores",  32'(scores_a),  32'h00);
        chk("start_ack",     32'(ack_a),     32'd0);

        // p0 scores; point stays high through HOLD
        tick();
        chk("p0_scores", 32'(scores_a),  32'h01);
        chk("p0_ack",    32'(ack_a),     32'd1);
        chk("p0_serve",  32'(serve_a),   32'd0);
        chk("p0_hold",   32'(in_play_a), 32'd0);
        wait_hold(1'b0, 32'h01);
        tick();
        chk("held_pt_scores", 32'(scores_a), 32'h02);
        chk("held_pt_ack",    32'(ack_a),    32'd1);
        point_a = 2'b00;
        wait_hold(1'b0, 32'h02);

        // Simultaneous points: lowest index wins
        point_a = 2'b11;
        tick();
        point_a = 2'b00;
        chk("simul_scores", 32'(scores_a), 32'h03);
        chk("simul_ack",    32'(ack_a),    32'd1);
        chk("simul_serve",  32'(serve_a),  32'd0);
        wait_hold(1'b0, 32'h03);

        // p1 scores to WIN_SCORE
        for (int k = 1; k <= 11; k++) begin
            point_a = 2'b10;
            tick();
            point_a = 2'b00;
            chk("p1_score", 32'(scores_a[7:4]), 32'(k));
            chk("p1_ack",   32'(ack_a),         32'd1);
            chk("p1_serve", 32'(serve_a),       32'd1);
            if (k < 11) wait_hold(1'b0, 32'(k << 4) | 32'h3);
        end
        chk("win_over",    32'(over_a),    32'd1);
        chk("win_winner",  32'(winner_a),  32'd1);
        chk("win_in_play", 32'(in_play_a), 32'd0);
        chk("win_scores",  32'(scores_a),  32'hB3);

        point_a = 2'b10;
        tick();
        tick();
        point_a = 2'b00;
        chk("over_pt_scores", 32'(scores_a), 32'hB3);
        chk("over_pt_ack",    32'(ack_a),    32'd0);
        chk("over_hold",      32'(over_a),   32'd1);
        chk("over_winner",    32'(winner_a), 32'd1);

        // Restart from OVER: scores and winner clear, serve_to kept
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_in_play", 32'(in_play_a), 32'd1);
        chk("restart_over",    32'(over_a),    32'd0);
        chk("restart_scores",  32'(scores_a),  32'h00);
        chk("restart_winner",  32'(winner_a),  32'd0);
        chk("restart_serve",   32'(serve_a),   32'd1);

        // Build 3 for p1, then start in PLAY is ignored
        for (int k = 1; k <= 3; k++) begin
            point_a = 2'b10;
            tick();
            point_a = 2'b00;
            wait_hold(1'b0, 32'(k << 4));
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("play_start_scores",  32'(scores_a),  32'h30);
        chk("play_start_in_play", 32'(in_play_a), 32'd1);

        // p0 to 5, reset mid-HOLD
        for (int k = 1; k <= 5; k++) begin
            point_a = 2'b01;
            tick();
            point_a = 2'b00;
            if (k < 5) wait_hold(1'b0, 32'h30 | 32'(k));
        end
        chk("pre_rst_scores", 32'(scores_a), 32'h35);
        tick();
        chk("pre_rst_hold", 32'(in_play_a), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midhold_rst_scores",  32'(scores_a),  32'h00);
        chk("midhold_rst_ack",     32'(ack_a),     32'd0);
        chk("midhold_rst_serve",   32'(serve_a),   32'd0);
        chk("midhold_rst_in_play", 32'(in_play_a), 32'd0);
        chk("midhold_rst_over",    32'(over_a),    32'd0);
        chk("midhold_rst_winner",  32'(winner_a),  32'd0);
        point_a = 2'b01;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_pt_scores", 32'(scores_a),  32'h00);
            chk("post_rst_in_play",   32'(in_play_a), 32'd0);
        end
        point_a = 2'b00;

        // 4-player build
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_in_play", 32'(in_play_b), 32'd1);
        point_b = 4'b1100;
        tick();
        point_b = 4'b0000;
        chk("b_p2_scores", 32'(scores_b), 32'h040);
        chk("b_p2_serve",  32'(serve_b),  32'd2);
        chk("b_p2_ack",    32'(ack_b),    32'd1);
        wait_hold(1'b1, 32'h040);
        point_b = 4'b1000;
        tick();
        point_b = 4'b0000;
        chk("b_p3_scores", 32'(scores_b), 32'h240);
        chk("b_p3_serve",  32'(serve_b),  32'd3);
        wait_hold(1'b1, 32'h240);
        for (int k = 2; k <= 7; k++) begin
            point_b = 4'b0100;
            tick();
            point_b = 4'b0000;
            chk("b_p2_run", 32'(scores_b), 32'h200 | 32'(k << 6));
            if (k < 7) wait_hold(1'b1, 32'h200 | 32'(k << 6));
        end
        chk("b_over",   32'(over_b),   32'd1);
        chk("b_winner", 32'(winner_b), 32'd2);
        start_b = 1'b1;
        point_b = 4'b0001;
        tick();
        start_b = 1'b0;
        point_b = 4'b0000;
        chk("b_restart_scores",  32'(scores_b),  32'h000);
        chk("b_restart_in_play", 32'(in_play_b), 32'd1);
        chk("b_restart_winner",  32'(winner_b),  32'd0);
        chk("b_restart_serve",   32'(serve_b),   32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
